// File: rtl/fir_stream_mc_if.sv
// Stream and coefficient-port bundle for fir_stream_mc.
// The filter connects through the slave modport; the driving side uses master.
interface fir_stream_mc_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned CH_W   = 1,
    parameter int unsigned ADDR_W = 3
);
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_channel;
    logic [1:0]        in_error;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_channel;
    logic [1:0]        out_error;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_we;
    logic              coef_ack;

    modport master (
        output in_data, in_channel, in_error, in_valid, out_ready,
               coef_addr, coef_data, coef_we,
        input  in_ready, out_data, out_channel, out_error, out_valid, coef_ack
    );

    modport slave (
        input  in_data, in_channel, in_error, in_valid, out_ready,
               coef_addr, coef_data, coef_we,
        output in_ready, out_data, out_channel, out_error, out_valid, coef_ack
    );
endinterface

// File: rtl/fir_stream_mc.sv
// Multi-channel streaming FIR: per-channel delay lines, one shared MAC, round + saturate.
// Optional FIR_SAT_FLAG_EN: ORs a clipping flag into out_error[1].
module fir_stream_mc #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned TAPS     = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = 1
) (
    input logic           clk_clk,
    input logic           reset_reset,
    fir_stream_mc_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    localparam int unsigned CI_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam logic signed [ACC_W-1:0] RND_K   = {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic signed [DATA_W-1:0] dline_q [CHANNELS][TAPS];
    logic signed [COEF_W-1:0] coef_q  [TAPS];
    logic signed [DATA_W-1:0] data_q;
    logic [CH_W-1:0]          ch_q;
    logic [1:0]               err_q;
    logic [ADDR_W-1:0]        tap_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic [CI_W-1:0]          ch_idx_c;
    logic                     ch_ok_c;
    logic                     coef_wr_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  rnd_c;
    logic signed [ACC_W-1:0]  shr_c;
    logic                     sat_hi_c;
    logic                     sat_lo_c;
    logic [DATA_W-1:0]        res_c;

    assign ch_idx_c  = CI_W'(ch_q);
    assign ch_ok_c   = 32'(ch_q) < CHANNELS;
    // A sample accept in IDLE takes priority over a coefficient write.
    assign coef_wr_c = (state_q == S_IDLE) && !bus.in_valid && bus.coef_we &&
                       (32'(bus.coef_addr) < TAPS);

    assign prod_c   = PROD_W'(dline_q[ch_idx_c][tap_q]) * PROD_W'(coef_q[tap_q]);
    assign rnd_c    = acc_q + RND_K;
    assign shr_c    = rnd_c >>> (COEF_W - 1);
    assign sat_hi_c = shr_c > SAT_MAX;
    assign sat_lo_c = shr_c < SAT_MIN;
    assign res_c    = sat_hi_c ? {1'b0, {(DATA_W-1){1'b1}}} :
                      sat_lo_c ? {1'b1, {(DATA_W-1){1'b0}}} :
                                 shr_c[DATA_W-1:0];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_LOAD;
            S_LOAD:  state_d = ch_ok_c ? S_MAC : S_IDLE;
            S_MAC:   if (tap_q == ADDR_W'(TAPS - 1)) state_d = S_ROUND;
            S_ROUND: state_d = S_OUT;
            S_OUT:   if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q         <= S_IDLE;
            data_q          <= '0;
            ch_q            <= '0;
            err_q           <= '0;
            tap_q           <= '0;
            acc_q           <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_data    <= '0;
            bus.out_channel <= '0;
            bus.out_error   <= '0;
            bus.out_valid   <= 1'b0;
            bus.coef_ack    <= 1'b0;
            for (int t = 0; t < int'(TAPS); t++) begin
                coef_q[t] <= '0;
                for (int c = 0; c < int'(CHANNELS); c++) dline_q[c][t] <= '0;
            end
        end else begin
            state_q      <= state_d;
            bus.in_ready <= (state_d == S_IDLE);
            bus.coef_ack <= coef_wr_c;
            if (coef_wr_c) coef_q[bus.coef_addr] <= bus.coef_data;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        data_q <= bus.in_data;
                        ch_q   <= bus.in_channel;
                        err_q  <= bus.in_error;
                    end
                end
                S_LOAD: begin
                    // Out-of-range channels leave every delay line untouched.
                    if (ch_ok_c) begin
                        for (int k = int'(TAPS) - 1; k > 0; k--)
                            dline_q[ch_idx_c][k] <= dline_q[ch_idx_c][k-1];
                        dline_q[ch_idx_c][0] <= data_q;
                    end
                    acc_q <= '0;
                    tap_q <= '0;
                end
                S_MAC: begin
                    acc_q <= acc_q + ACC_W'(prod_c);
                    tap_q <= tap_q + ADDR_W'(1);
                end
                S_ROUND: begin
                    bus.out_data    <= res_c;
                    bus.out_channel <= ch_q;
`ifdef FIR_SAT_FLAG_EN
                    bus.out_error   <= {err_q[1] | sat_hi_c | sat_lo_c, err_q[0]};
`else
                    bus.out_error   <= err_q;
`endif
                    bus.out_valid   <= 1'b1;
                end
                S_OUT: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_stream_mc.sv
// Self-checking bench for fir_stream_mc (TAPS=4, CHANNELS=2, CH_W=2) with an output scoreboard.
module tb_fir_stream_mc;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned TAPS     = 4;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned ADDR_W   = 2;
    localparam int          LAT      = TAPS + 2;
`ifdef FIR_SAT_FLAG_EN
    localparam logic [1:0] SAT_FLAG = 2'b10;
`else
    localparam logic [1:0] SAT_FLAG = 2'b00;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ch;
        logic [1:0]  err;
    } exp_t;

    logic clk_clk = 1'b0;
    logic reset_reset;
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   timeouts = 0;

    always #5 clk_clk = ~clk_clk;

    fir_stream_mc_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .CH_W(CH_W), .ADDR_W(ADDR_W)) bus ();

    fir_stream_mc #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS), .CH_W(CH_W)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .bus        (bus)
    );

    // Scoreboard: compare each output handshake against the oldest expected result
    always @(negedge clk_clk) begin
        if (!reset_reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_output data=%0d ch=%0d", $signed(bus.out_data), bus.out_channel);
            end else begin
                passed++;
                mon_e = sb_q.pop_front();
                checks++;
                if (bus.out_data !== mon_e.data)
                    $display("FAIL out_data got=%0d exp=%0d", $signed(bus.out_data), $signed(mon_e.data));
                else passed++;
                checks++;
                if (bus.out_channel !== mon_e.ch)
                    $display("FAIL out_channel got=%0d exp=%0d", bus.out_channel, mon_e.ch);
                else passed++;
                checks++;
                if (bus.out_error !== mon_e.err)
                    $display("FAIL out_error got=%b exp=%b", bus.out_error, mon_e.err);
                else passed++;
            end
        end
    end

    task automatic do_reset();
        reset_reset = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1 reset_reset = 1'b0;
    endtask

    task automatic write_coef(input logic [ADDR_W-1:0] a, input logic [15:0] v, output logic ack);
        bus.coef_addr = a;
        bus.coef_data = v;
        bus.coef_we   = 1'b1;
        @(posedge clk_clk); #1;
        bus.coef_we   = 1'b0;
        ack = bus.coef_ack;
    endtask

    task automatic load_coefs(input logic [15:0] c0, c1, c2, c3, output int acks);
        logic       a;
        logic [15:0] tbl [4];
        tbl[0] = c0; tbl[1] = c1; tbl[2] = c2; tbl[3] = c3;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            write_coef(ADDR_W'(i), tbl[i], a);
            if (a === 1'b1) acks++;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] ch, input logic [1:0] err,
                        input bit expect_out, input logic [15:0] exp_d, input logic [1:0] exp_err);
        int n = 0;
        if (expect_out) sb_q.push_back('{data: exp_d, ch: ch, err: exp_err});
        bus.in_data    = d;
        bus.in_channel = ch;
        bus.in_error   = err;
        bus.in_valid   = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk_clk); #1;
            n++;
        end
        if (n >= 100) timeouts++;
        @(posedge clk_clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            @(posedge clk_clk); #1;
            n++;
        end
        if (n >= 64) timeouts++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin
            @(posedge clk_clk); #1;
            n++;
        end
        if (n >= 64) timeouts++;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else passed++;
        checks++; if (bus.coef_ack !== 1'b0) $display("FAIL reset_coef_ack got=%b exp=0", bus.coef_ack); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else passed++;
        checks++; if (bus.out_data !== 16'd0) $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); else passed++;
        send(16'd1000, 2'd0, 2'b00, 1'b1, 16'd0, 2'b00);
        wait_valid(n);
        checks++; if (n !== LAT) $display("FAIL zero_coef_latency got=%0d exp=%0d", n, LAT); else passed++;
        wait_idle();
    endtask

    task automatic test_taps();
        int n, acks;
        logic [15:0] smp [3];
        logic [15:0] res [3];
        smp[0] = 16'd1000; smp[1] = 16'd0;   smp[2] = 16'd0;
        res[0] = 16'd500;  res[1] = 16'd250; res[2] = 16'd0;
        do_reset();
        load_coefs(16'd16384, 16'd8192, 16'd0, 16'd0, acks);
        checks++; if (acks !== 4) $display("FAIL coef_acks got=%0d exp=4", acks); else passed++;
        for (int i = 0; i < 3; i++) begin
            send(smp[i], 2'd0, 2'b00, 1'b1, res[i], 2'b00);
            wait_valid(n);
            checks++; if (n !== LAT) $display("FAIL taps_latency_%0d got=%0d exp=%0d", i, n, LAT); else passed++;
            wait_idle();
        end
    endtask

    task automatic test_channels();
        int n, acks;
        logic [15:0] smp [3];
        logic [1:0]  chn [3];
        logic [15:0] res [3];
        smp[0] = 16'd1000; chn[0] = 2'd0; res[0] = 16'd500;
        smp[1] = 16'd2000; chn[1] = 2'd1; res[1] = 16'd1000;
        smp[2] = 16'd0;    chn[2] = 2'd0; res[2] = 16'd500;
        do_reset();
        load_coefs(16'd16384, 16'd16384, 16'd0, 16'd0, acks);
        for (int i = 0; i < 3; i++) begin
            send(smp[i], chn[i], 2'b00, 1'b1, res[i], 2'b00);
            wait_valid(n);
            wait_idle();
        end
    endtask

    task automatic test_saturation();
        int n, acks;
        do_reset();
        load_coefs(16'd32767, 16'd32767, 16'd32767, 16'd32767, acks);
        send(16'd32767, 2'd0, 2'b00, 1'b1, 16'd32766, 2'b00);
        wait_valid(n); wait_idle();
        send(16'd32767, 2'd0, 2'b00, 1'b1, 16'd32767, SAT_FLAG);
        wait_valid(n); wait_idle();
        send(16'd32767, 2'd0, 2'b01, 1'b1, 16'd32767, 2'b01 | SAT_FLAG);
        wait_valid(n); wait_idle();
        send(16'h8000, 2'd1, 2'b00, 1'b1, 16'h8001, 2'b00);
        wait_valid(n); wait_idle();
        send(16'h8000, 2'd1, 2'b10, 1'b1, 16'h8000, 2'b10);
        wait_valid(n); wait_idle();
    endtask

    task automatic test_backpressure();
        int n, acks;
        do_reset();
        load_coefs(16'd16384, 16'd0, 16'd0, 16'd0, acks);
        bus.out_ready = 1'b0;
        send(16'd1000, 2'd1, 2'b01, 1'b1, 16'd500, 2'b01);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_valid_%0d got=%b exp=1", i, bus.out_valid); else passed++;
            checks++; if (bus.out_data !== 16'd500) $display("FAIL hold_data_%0d got=%0d exp=500", i, bus.out_data); else passed++;
            checks++; if (bus.out_channel !== 2'd1) $display("FAIL hold_channel_%0d got=%0d exp=1", i, bus.out_channel); else passed++;
            checks++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready_%0d got=%b exp=0", i, bus.in_ready); else passed++;
            bus.coef_addr = 2'd0;
            bus.coef_data = 16'd0;
            bus.coef_we   = 1'b1;
            @(posedge clk_clk); #1;
            checks++; if (bus.coef_ack !== 1'b0) $display("FAIL busy_coef_ack_%0d got=%b exp=0", i, bus.coef_ack); else passed++;
        end
        bus.coef_we   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk_clk); #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_hs_out_valid got=%b exp=0", bus.out_valid); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_hs_in_ready got=%b exp=1", bus.in_ready); else passed++;
        send(16'd2000, 2'd1, 2'b00, 1'b1, 16'd1000, 2'b00);
        wait_valid(n); wait_idle();
    endtask

    task automatic test_reset_midstream();
        int n, acks, seen;
        do_reset();
        load_coefs(16'd16384, 16'd16384, 16'd0, 16'd0, acks);
        send(16'd1000, 2'd1, 2'b00, 1'b1, 16'd500, 2'b00);
        wait_valid(n); wait_idle();
        send(16'd2000, 2'd1, 2'b00, 1'b0, 16'd0, 2'b00);
        repeat (2) begin @(posedge clk_clk); #1; end
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); else passed++;
        seen = 0;
        repeat (10) begin
            @(posedge clk_clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL midrst_no_output got=%0d exp=0", seen); else passed++;
        load_coefs(16'd16384, 16'd16384, 16'd0, 16'd0, acks);
        send(16'd4000, 2'd1, 2'b00, 1'b1, 16'd2000, 2'b00);
        wait_valid(n); wait_idle();
        send(16'd7000, 2'd3, 2'b00, 1'b0, 16'd0, 2'b00);
        @(posedge clk_clk); #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL bad_ch_in_ready got=%b exp=1", bus.in_ready); else passed++;
        seen = 0;
        repeat (10) begin
            @(posedge clk_clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL bad_ch_no_output got=%0d exp=0", seen); else passed++;
        send(16'd0, 2'd1, 2'b00, 1'b1, 16'd2000, 2'b00);
        wait_valid(n); wait_idle();
        send(16'd0, 2'd0, 2'b00, 1'b1, 16'd0, 2'b00);
        wait_valid(n); wait_idle();
    endtask

    initial begin
        reset_reset    = 1'b1;
        bus.in_data    = '0;
        bus.in_channel = '0;
        bus.in_error   = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.coef_addr  = '0;
        bus.coef_data  = '0;
        bus.coef_we    = 1'b0;
        @(posedge clk_clk); #1;
        test_reset();
        test_taps();
        test_channels();
        test_saturation();
        test_backpressure();
        test_reset_midstream();
        repeat (4) @(posedge clk_clk);
        #1;
        checks++; if (sb_q.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size()); else passed++;
        checks++; if (timeouts !== 0) $display("FAIL timeouts got=%0d exp=0", timeouts); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
